// File: rtl/rx_fd_pkg.sv
// Shared definitions for the serial receive datapath.
// State encodings and parity encoding (shared with tx_fd).
package rx_fd_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/rx_fd_sync2.sv
// Generic two-flop synchronizer with configurable reset value.
// Used to bring the asynchronous serial line into the clk domain.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_fd.sv
// Serial receiver: start, 7/8 data bits LSB first, optional parity,
// 1/2 stop bits, sampled mid-bit from an external oversampling tick.
module rx_fd #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       serial_in,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop_bits,
  input  logic       data_width,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);
  import rx_fd_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_en_l;
  logic          par_type_l;
  logic          stop_l;
  logic          width_l;
  logic          par_err_r;
  logic          fe_r;
  logic [7:0]    word;
  logic          last_bit;
  logic          at_end;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (rx_s)
  );

  // In 7-bit mode the word sits in [7:1]; [0] is the cleared seed bit
  always_comb begin
    word     = width_l ? shift_reg : {1'b0, shift_reg[7:1]};
    last_bit = (bit_cnt == (width_l ? 3'd7 : 3'd6));
    at_end   = (tick_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_en_l      <= 1'b0;
      par_type_l    <= PARITY_EVEN;
      stop_l        <= 1'b0;
      width_l       <= 1'b0;
      par_err_r     <= 1'b0;
      fe_r          <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (sample_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state      <= START;
              tick_cnt   <= '0;
              bit_cnt    <= '0;
              shift_reg  <= '0;
              par_err_r  <= 1'b0;
              fe_r       <= 1'b0;
              busy       <= 1'b1;
              par_en_l   <= parity_en;
              par_type_l <= parity_type;
              stop_l     <= stop_bits;
              width_l    <= data_width;
            end
          end
          START: begin
            if (tick_cnt == MID) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (at_end) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              if (last_bit) begin
                state <= par_en_l ? PARITY : STOP1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (at_end) begin
              tick_cnt  <= '0;
              par_err_r <= rx_s ^ (^word) ^ par_type_l;
              state     <= STOP1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP1, STOP2: begin
            if (at_end) begin
              tick_cnt <= '0;
              if (state == STOP1 && stop_l) begin
                fe_r  <= ~rx_s;
                state <= STOP2;
              end else begin
                data_out      <= word;
                parity_error  <= par_en_l & par_err_r;
                framing_error <= fe_r | ~rx_s;
                data_valid    <= 1'b1;
                busy          <= 1'b0;
                state         <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_fd.sv
// Scoreboard bench for rx_fd: frames are driven bit by bit, the
// expected word and flags are queued at send time and popped after.
module tb_rx_fd;

  localparam int BIT_CLK = 64;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       serial_in = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       stop_bits = 1'b0;
  logic       data_width = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vld_cnt = 0;
  bit   wide = 1'b0;
  bit   busy_seen = 1'b0;
  bit   prev_dv = 1'b0;
  logic [7:0] cap_data = '0;
  logic cap_pe = 1'b0;
  logic cap_fe = 1'b0;
  int   tcnt = 0;

  rx_fd #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .serial_in     (serial_in),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .data_width    (data_width),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt        <= (tcnt == 3) ? 0 : tcnt + 1;
    sample_tick <= (tcnt == 3);
  end

  always @(negedge clk) begin
    if (data_valid) begin
      cap_data = data_out;
      cap_pe   = parity_error;
      cap_fe   = framing_error;
      vld_cnt++;
      if (prev_dv) wide = 1'b1;
    end
    prev_dv = data_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit w,
                            input bit pen, input bit ptype,
                            input bit pbit, input bit sb2,
                            input bit stop_val);
    exp_t e;
    logic [7:0] dm;
    dm = w ? d : {1'b0, d[6:0]};
    e.data = dm;
    e.pe   = pen && (pbit != ((^dm) ^ ptype));
    e.fe   = !stop_val;
    sb.push_back(e);
    @(negedge clk);
    data_width  = w;
    parity_en   = pen;
    parity_type = ptype;
    stop_bits   = sb2;
    drive_bit(1'b0);
    for (int i = 0; i < (w ? 8 : 7); i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop_val);
    if (sb2) drive_bit(stop_val);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL rst_pe got=%b exp=0", parity_error); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL rst_fe got=%b exp=0", framing_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic test_8n1();
    exp_t e;
    int v0;
    v0 = vld_cnt; wide = 1'b0;
    send_frame(8'hA5, 1, 0, 0, 0, 0, 1);
    e = sb.pop_front();
    checks++; if (vld_cnt !== v0 + 1) begin errors++; $display("FAIL 8n1_pulses got=%0d exp=%0d", vld_cnt - v0, 1); end
    checks++; if (wide !== 1'b0) begin errors++; $display("FAIL 8n1_pulse_width got=wide exp=1clk"); end
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL 8n1_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL 8n1_pe got=%b exp=%b", cap_pe, e.pe); end
    checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL 8n1_fe got=%b exp=%b", cap_fe, e.fe); end
  endtask

  task automatic test_7e2();
    exp_t e;
    int v0;
    v0 = vld_cnt;
    send_frame(8'h35, 0, 1, 0, 0, 1, 1);
    e = sb.pop_front();
    checks++; if (vld_cnt !== v0 + 1) begin errors++; $display("FAIL 7e2_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL 7e2_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL 7e2_pe got=%b exp=%b", cap_pe, e.pe); end
    checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL 7e2_fe got=%b exp=%b", cap_fe, e.fe); end
    send_frame(8'h35, 0, 1, 0, 1, 1, 1);
    e = sb.pop_front();
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL 7e2_bad_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL 7e2_bad_pe got=%b exp=%b", cap_pe, e.pe); end
  endtask

  task automatic test_odd_parity();
    exp_t e;
    send_frame(8'hFF, 1, 1, 1, 1, 0, 1);
    e = sb.pop_front();
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL odd_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL odd_pe got=%b exp=%b", cap_pe, e.pe); end
    send_frame(8'hFF, 1, 1, 1, 0, 0, 1);
    e = sb.pop_front();
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL odd_bad_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL odd_bad_pe got=%b exp=%b", cap_pe, e.pe); end
  endtask

  task automatic test_framing();
    exp_t e;
    int v0;
    v0 = vld_cnt;
    send_frame(8'h0F, 1, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    checks++; if (vld_cnt !== v0 + 1) begin errors++; $display("FAIL fe_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL fe_flag got=%b exp=%b", cap_fe, e.fe); end
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL fe_data got=%h exp=%h", cap_data, e.data); end
    send_frame(8'h81, 1, 0, 0, 0, 0, 1);
    e = sb.pop_front();
    checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL fe_clear got=%b exp=%b", cap_fe, e.fe); end
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL fe_next_data got=%h exp=%h", cap_data, e.data); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vld_cnt; busy_seen = 1'b0;
    @(negedge clk);
    serial_in = 1'b0;
    repeat (12) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got=%b exp=1", busy_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL glitch_no_valid got=%0d exp=0", vld_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int v0;
    v0 = vld_cnt;
    fork
      send_frame(8'hAA, 1, 0, 0, 0, 0, 1);
      begin
        repeat ((1 + 4) * BIT_CLK + 33) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got=%h exp=00", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_clr got=%b exp=0", busy); end
        checks++; if ({data_valid, parity_error, framing_error} !== 3'b000) begin
          errors++; $display("FAIL mid_flags got=%b exp=000", {data_valid, parity_error, framing_error});
        end
      end
    join
    void'(sb.pop_front());
    checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL mid_no_valid got=%0d exp=0", vld_cnt - v0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(8'h3C, 1, 0, 0, 0, 0, 1);
    e = sb.pop_front();
    checks++; if (vld_cnt !== v0 + 1) begin errors++; $display("FAIL post_rst_pulses got=%0d exp=1", vld_cnt - v0); end
    checks++; if (cap_data !== e.data) begin errors++; $display("FAIL post_rst_data got=%h exp=%h", cap_data, e.data); end
    checks++; if (cap_pe !== e.pe || cap_fe !== e.fe) begin
      errors++; $display("FAIL post_rst_flags got=%b%b exp=%b%b", cap_pe, cap_fe, e.pe, e.fe);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_odd_parity();
    test_framing();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
